crc_stream_checker: RTL and testbench
=====================================

// Module: crc_stream_checker
// PURPOSE
//  Parametrised streaming CRC engine for the Sigma Delta DAQ link layer.
//  - Consumes a framed word stream over a valid/ready handshake.
//  - Computes a reflected (LSB-first) CRC over the frame.
//  - Reports the final register value and a residue match.
//  - Holds its result until acknowledged, then re-arms for the next frame.
// PARAMETERS
//  CRC_W      8        CRC register width in bits (>=4)
//  DATA_W     8        input word width in bits (>=1)
//  POLY       8'hC6    reflected polynomial, CRC_W bits, XORed after right shift
//  INIT       8'h0D    register value loaded at frame start
//  MATCH_VAL  8'h00    residue that signals a good frame
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  i_valid    in   1       i_data is valid this cycle
//  o_ready    out  1       engine accepts a word this cycle
//  i_data     in   DATA_W  payload word (CRC bytes appended for check)
//  i_last     in   1       qualifies the final word of the frame
//  i_ack      in   1       consumer has taken the result; re-arm
//  i_clear    in   1       synchronous abort of the current frame
//  o_done     out  1       result valid; held until i_ack
//  o_match    out  1       final register == MATCH_VAL; valid while o_done
//  o_crc      out  CRC_W   running/final CRC register
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, o_ready=0, o_done=0, o_match=0, o_crc=INIT.
//  - Word update: for j=0..DATA_W-1 (LSB first):
//      if crc[0]!=d[j] then crc=(crc>>1)^POLY else crc=crc>>1.
//    No final XOR. Widths are fixed by parameters; no truncation.
//  - Accept = i_valid && o_ready. Only accepted words update the CRC.
//  - States:
//    - IDLE: load crc=INIT, clear match/done; next state CALC unconditionally (1 cycle).
//    - CALC: o_ready=1.
//      - Accepted word updates crc at the edge.
//      - Accept && i_last -> CHECK; otherwise stay in CALC.
//    - CHECK: o_ready=0; register o_match=(crc==MATCH_VAL), set o_done=1; next state DONE.
//    - DONE: o_ready=0; o_done, o_match, o_crc frozen.
//      - i_ack -> IDLE; done/match clear at that edge.
//  - Latency: last word accepted at edge N -> o_done=1 after edge N+1.
//    Earliest next accept is 2 cycles after i_ack.
//  - o_crc is registered; it reflects every accepted word one cycle later.
//  - i_last without i_valid is ignored.
//  - i_ack outside DONE is ignored.
//  - i_clear, any state: next state IDLE, done/match=0.
//    - i_clear wins over a simultaneous accept; that word is dropped, o_ready still shows 1.
//    - i_clear wins over a simultaneous i_ack.
//  - Reset asserted mid-frame: immediate return to reset values; partial frame discarded.
//  - Frames of length 1 are legal (i_valid && i_last on the first accept).
// STRUCTURE
//  - Package crc_pkg:
//    - state enum {IDLE, CALC, CHECK, DONE}.
//    - default POLY/INIT/MATCH constants.
//    - automatic function crc_update(crc, data) parametrised by widths.
//  - Sub-module crc_step: combinational, one DATA_W word per call; instantiated once in CALC.
//  - Top: FSM plus output registers only.
// TESTING (defaults)
//  1. Reset, then single word 0x00 with i_last -> o_crc=0xC7; o_match=0; o_done 1 cycle after CHECK.
//  2. Frame {0x00,0xC7} -> o_crc=0x00, o_match=1.
//     o_done held 5 cycles without i_ack; after i_ack, o_done=0 and o_crc=0x0D.
//  3. Frame {0x00,0xC6} -> o_crc=0x13, o_match=0.
//  4. Frame {0x00,0xC7} with i_valid gaps between words -> identical result to case 2.
//     i_data changes while i_valid=0 have no effect.
//  5. i_clear together with the second word of {0x00,0xC7} -> returns to IDLE, word dropped.
//     Re-sent full frame gives o_match=1.
//  6. Async reset mid-frame (between clock edges) -> outputs take reset values immediately.
//     A new frame {0x00,0xC7} then matches.

Source files
------------

// File: rtl/crc_pkg.sv
// Package for the streaming CRC checker.
// Contents:
//   state_e     FSM states of the checker
//   *_DEF       default CRC width, data width, polynomial, init and residue values
//   crc_update  bit-serial reflected CRC update over one data word
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int         CRC_W_DEF  = 8;
    localparam int         DATA_W_DEF = 8;
    localparam logic [7:0] POLY_DEF   = 8'hC6;
    localparam logic [7:0] INIT_DEF   = 8'h0D;
    localparam logic [7:0] MATCH_DEF  = 8'h00;

    // Widest CRC register / data word the helper can process. Callers
    // zero-extend their operands into this width and truncate the result.
    localparam int MAX_W = 64;

    // Reflected (LSB-first) update of crc by the low data_w bits of data.
    // The upper bits of crc and poly must be zero; a right shift then keeps
    // them zero, so the result is exact for any register width <= MAX_W.
    function automatic logic [MAX_W-1:0] crc_update(
        input logic [MAX_W-1:0] crc,
        input logic [MAX_W-1:0] data,
        input logic [MAX_W-1:0] poly,
        input int               data_w
    );
        logic [MAX_W-1:0] c;
        c = crc;
        for (int j = 0; j < MAX_W; j++) begin
            if (j < data_w) begin
                if (c[0] != data[j]) begin
                    c = (c >> 1) ^ poly;
                end else begin
                    c = c >> 1;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC step: advances a CRC register by one DATA_W-bit word.
// Ports:
//   crc_i   current CRC register value
//   data_i  data word, consumed LSB first
//   crc_o   CRC register value after the whole word
module crc_step
    import crc_pkg::*;
#(
    parameter int               CRC_W  = CRC_W_DEF,
    parameter int               DATA_W = DATA_W_DEF,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(POLY_DEF)
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    // Operands are widened to the helper's width; the result never has
    // bits above CRC_W set, so the truncating cast loses nothing.
    assign crc_o = CRC_W'(crc_update(MAX_W'(crc_i), MAX_W'(data_i), MAX_W'(POLY), DATA_W));

endmodule

// File: rtl/crc_stream_checker.sv
// Streaming CRC checker: accepts a framed word stream over valid/ready,
// runs a reflected CRC over it and reports the final register plus a
// residue match, holding the result until acknowledged.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   i_valid  i_data valid this cycle
//   o_ready  engine accepts a word this cycle (CALC state)
//   i_data   payload word
//   i_last   final word of the frame (only meaningful with an accept)
//   i_ack    result consumed; re-arm (only honoured in DONE)
//   i_clear  synchronous abort of the current frame, any state
//   o_done   result valid, held until i_ack
//   o_match  final register equals MATCH_VAL, valid while o_done
//   o_crc    running / final CRC register
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int               CRC_W     = CRC_W_DEF,
    parameter int               DATA_W    = DATA_W_DEF,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(POLY_DEF),
    parameter logic [CRC_W-1:0] INIT      = CRC_W'(INIT_DEF),
    parameter logic [CRC_W-1:0] MATCH_VAL = CRC_W'(MATCH_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ack,
    input  logic              i_clear,
    output logic              o_done,
    output logic              o_match,
    output logic [CRC_W-1:0]  o_crc
);

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               done_q, done_d;
    logic               match_q, match_d;
    logic [CRC_W-1:0]   step_crc;
    logic               accept;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (i_data),
        .crc_o  (step_crc)
    );

    // o_ready depends on state only, so it still reads 1 while i_clear
    // drops the word presented in the same cycle.
    assign o_ready = (state_q == CALC);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        done_d  = done_q;
        match_d = match_q;

        unique case (state_q)
            IDLE: begin
                crc_d   = INIT;
                done_d  = 1'b0;
                match_d = 1'b0;
                state_d = CALC;
            end
            CALC: begin
                if (accept) begin
                    crc_d = step_crc;
                    if (i_last) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                match_d = (crc_q == MATCH_VAL);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // INIT is loaded on the ack edge itself so the register
                // already shows the fresh seed while the FSM sits in IDLE.
                if (i_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    match_d = 1'b0;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything above, including an accept or an ack.
        if (i_clear) begin
            state_d = IDLE;
            done_d  = 1'b0;
            match_d = 1'b0;
            crc_d   = INIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign o_done  = done_q;
    assign o_match = match_q;
    assign o_crc   = crc_q;

endmodule

// File: tb/tb_crc_stream_checker.sv
// Scoreboard bench for crc_stream_checker at default parameters.
// The stimulus process pushes the expected {crc, match} of each frame;
// a monitor pops and compares whenever o_done rises.
module tb_crc_stream_checker;

    localparam logic [7:0] POLY_V  = 8'hC6;
    localparam logic [7:0] INIT_V  = 8'h0D;
    localparam logic [7:0] MATCH_V = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       i_last;
    logic       i_ack;
    logic       i_clear;
    logic       o_done;
    logic       o_match;
    logic [7:0] o_crc;

    always #5 clk = ~clk;

    crc_stream_checker dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_ack   (i_ack),
        .i_clear (i_clear),
        .o_done  (o_done),
        .o_match (o_match),
        .o_crc   (o_crc)
    );

    typedef struct packed {
        logic [7:0] crc;
        logic       match;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] frame[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the first n words of the frame laid out as one LSB-first
    // bit stream, divided bit by bit starting from the seed.
    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] c;
        bit         stream[$];
        c = INIT_V;
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 8; b++) begin
                stream.push_back(frame[w][b]);
            end
        end
        foreach (stream[k]) begin
            if (c[0] != stream[k]) c = (c >> 1) ^ POLY_V;
            else                   c = c >> 1;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. Presents one word, waits for ready
    // and checks the registered CRC right after the accepting edge.
    task automatic send_word(input int idx, input logic last);
        bit ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = frame[idx];
        i_last  = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 8'($urandom);
        i_last  = 1'($urandom);
        check("running_crc", 32'(o_crc), 32'(model_crc(idx + 1)));
    endtask

    // Sends the whole frame queue, waits for the result, holds it for
    // `hold` cycles, then acknowledges.
    task automatic run_frame(input int hold, input bit gaps, input bit spec_chk,
                             input logic [7:0] spec_crc, input logic spec_match);
        exp_t e;
        int   waited;
        e.crc   = model_crc(frame.size());
        e.match = (e.crc == MATCH_V);
        for (int i = 0; i < frame.size(); i++) begin
            if (gaps && i > 0) begin
                int g = (i == 1) ? 2 : int'($urandom_range(0, 3));
                for (int k = 0; k < g; k++) begin
                    i_valid = 1'b0;
                    i_data  = 8'($urandom);
                    i_last  = 1'($urandom);
                    i_ack   = 1'($urandom);
                    tick();
                end
                i_ack = 1'b0;
            end
            if (i == frame.size() - 1) sb_q.push_back(e);
            send_word(i, i == frame.size() - 1);
        end
        @(negedge clk);
        check("done_early", 32'(o_done), 32'd0);
        waited = 0;
        while (!o_done && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("done_latency", 32'(waited), 32'd1);
        if (spec_chk) begin
            check("spec_crc", 32'(o_crc), 32'(spec_crc));
            check("spec_match", 32'(o_match), 32'(spec_match));
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("done_held", 32'(o_done), 32'd1);
            check("crc_frozen", 32'(o_crc), 32'(e.crc));
        end
        @(posedge clk);
        #1;
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("ack_done_clr", 32'(o_done), 32'd0);
        check("ack_crc_init", 32'(o_crc), 32'(INIT_V));
        check("ack_not_ready", 32'(o_ready), 32'd0);
    endtask

    // Monitor: compares against the scoreboard whenever a result appears.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(o_done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_crc", 32'(o_crc), 32'(e.crc));
                    check("sb_match", 32'(o_match), 32'(e.match));
                    $display("frame result crc=%02h match=%0d expected crc=%02h match=%0d",
                             o_crc, o_match, e.crc, e.match);
                end
            end
            prev_done = o_done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_last  = 1'b0;
        i_ack   = 1'b0;
        i_clear = 1'b0;
        #2;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_match", 32'(o_match), 32'd0);
        check("rst_crc", 32'(o_crc), 32'(INIT_V));
        tick();
        tick();
        reset = 1'b0;

        // Case 1: single word frame.
        frame = {8'h00};
        run_frame(1, 1'b0, 1'b1, 8'hC7, 1'b0);
        // Case 2: good frame, result held five cycles.
        frame = {8'h00, 8'hC7};
        run_frame(5, 1'b0, 1'b1, 8'h00, 1'b1);
        // Case 3: corrupted CRC byte.
        frame = {8'h00, 8'hC6};
        run_frame(1, 1'b0, 1'b1, 8'h13, 1'b0);
        // Case 4: valid gaps with changing data.
        frame = {8'h00, 8'hC7};
        run_frame(1, 1'b1, 1'b1, 8'h00, 1'b1);

        // Case 5: clear collides with the second word.
        frame = {8'h00, 8'hC7};
        send_word(0, 1'b0);
        i_valid = 1'b1;
        i_data  = 8'hC7;
        i_last  = 1'b1;
        i_clear = 1'b1;
        @(negedge clk);
        check("clear_ready", 32'(o_ready), 32'd1);
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("clear_crc", 32'(o_crc), 32'(INIT_V));
        check("clear_not_ready", 32'(o_ready), 32'd0);
        tick();
        tick();
        check("clear_no_done", 32'(o_done), 32'd0);
        run_frame(1, 1'b0, 1'b1, 8'h00, 1'b1);

        // Case 6: asynchronous reset between edges mid-frame.
        frame = {8'h00, 8'hC7};
        send_word(0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_crc", 32'(o_crc), 32'(INIT_V));
        check("arst_ready", 32'(o_ready), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        tick();
        reset = 1'b0;
        run_frame(1, 1'b0, 1'b1, 8'h00, 1'b1);

        // Randomised frames, half of them carrying their own CRC.
        for (int f = 0; f < 24; f++) begin
            frame.delete();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) frame.push_back(model_crc(n));
            run_frame(int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 8'h00, 1'b0);
        end

        tick();
        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
